// File: rtl/hesap_cekirdegi.sv
// Handshaked unsigned arithmetic core: add/sub/mul/div/isqrt with iterative datapaths.
// Optional macro HESAP_IPTAL_EN adds an 'iptal' abort input active in the compute state.
module hesap_cekirdegi #(
  parameter int GENISLIK = 32,
  parameter int SAYAC_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    basla,
  input  logic [GENISLIK-1:0]     sayi1,
  input  logic [GENISLIK-1:0]     sayi2,
  input  logic [2:0]              tur,
`ifdef HESAP_IPTAL_EN
  input  logic                    iptal,
`endif
  output logic [2*GENISLIK-1:0]   sonuc,
  output logic                    hazir,
  output logic                    gecerli,
  output logic                    tasma,
  output logic                    mesgul
);

  localparam int G  = GENISLIK;
  localparam int W2 = 2 * GENISLIK;
  localparam logic [SAYAC_W-1:0] CNT_ONE  = SAYAC_W'(1);
  localparam logic [SAYAC_W-1:0] CNT_FULL = SAYAC_W'(GENISLIK);
  localparam logic [SAYAC_W-1:0] CNT_HALF = SAYAC_W'(GENISLIK / 2);

  typedef enum logic [1:0] {BOS, HESAP, BITTI} durum_e;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIV  = 3'b011,
    OP_SQRT = 3'b100
  } islem_e;

  durum_e             state_q, state_d;
  logic [SAYAC_W-1:0] cnt_q, cnt_d;
  logic [G-1:0]       op_a_q, op_a_d;
  logic [G-1:0]       op_b_q, op_b_d;   // divisor, or the root being built for sqrt
  logic [2:0]         tur_q, tur_d;
  logic [W2:0]        acc_q, acc_d;
  logic [W2-1:0]      sonuc_q, sonuc_d;
  logic               hazir_q, hazir_d;
  logic               gecerli_q, gecerli_d;
  logic               tasma_q, tasma_d;
  logic               mesgul_q, mesgul_d;

  // Multiply step: add A into the upper half when the multiplier LSB is set, then shift right.
  logic [G:0]  mul_sum;
  logic [W2:0] mul_next;
  assign mul_sum  = acc_q[W2:G] + {1'b0, (acc_q[0] ? op_a_q : {G{1'b0}})};
  assign mul_next = {1'b0, mul_sum, acc_q[G-1:1]};

  // Restoring divide step: {remainder, dividend} shifts left, quotient bits enter at the LSB.
  logic [W2:0] div_sh, div_next;
  logic [G:0]  div_trial;
  logic        div_ge;
  assign div_sh    = {acc_q[W2-1:0], 1'b0};
  assign div_ge    = div_sh[W2:G] >= {1'b0, op_b_q};
  assign div_trial = div_sh[W2:G] - {1'b0, op_b_q};
  assign div_next  = {(div_ge ? div_trial : div_sh[W2:G]), div_sh[G-1:1], div_ge};

  // Non-restoring sqrt: signed partial remainder in acc[W2:G], radicand pairs leave from acc[G-1:G-2].
  logic [G:0]  sq_sh, sq_r_new;
  logic [W2:0] sq_next;
  logic [G-1:0] sq_q_next;
  assign sq_sh     = {acc_q[W2-2:G], acc_q[G-1:G-2]};
  assign sq_r_new  = acc_q[W2] ? (sq_sh + {op_b_q[G-2:0], 2'b11})
                               : (sq_sh - {op_b_q[G-2:0], 2'b01});
  assign sq_next   = {sq_r_new, acc_q[G-3:0], 2'b00};
  assign sq_q_next = {op_b_q[G-2:0], ~sq_r_new[G]};

  logic [G:0]    add_sum, sub_diff;
  logic [W2-1:0] res_sonuc;
  logic          res_gecerli, res_tasma;
  assign add_sum  = {1'b0, op_a_q} + {1'b0, op_b_q};
  assign sub_diff = {1'b0, op_a_q} - {1'b0, op_b_q};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    res_sonuc   = '0;
    res_gecerli = 1'b0;
    res_tasma   = 1'b0;
    case (tur_q)
      OP_ADD: begin
        res_sonuc   = {{(G-1){1'b0}}, add_sum};
        res_gecerli = 1'b1;
        res_tasma   = add_sum[G];
      end
      OP_SUB: begin
        res_sonuc   = {{(G-1){sub_diff[G]}}, sub_diff};
        res_gecerli = 1'b1;
        res_tasma   = sub_diff[G];
      end
      OP_MUL: begin
        res_sonuc   = acc_q[W2-1:0];
        res_gecerli = 1'b1;
        res_tasma   = |acc_q[W2-1:G];
      end
      OP_DIV: begin
        if (op_b_q == '0) begin
          res_tasma = 1'b1;
        end else begin
          res_sonuc   = acc_q[W2-1:0];
          res_gecerli = 1'b1;
        end
      end
      OP_SQRT: begin
        res_sonuc   = {{G{1'b0}}, op_b_q};
        res_gecerli = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    tur_d     = tur_q;
    acc_d     = acc_q;
    sonuc_d   = sonuc_q;
    hazir_d   = 1'b0;
    gecerli_d = gecerli_q;
    tasma_d   = tasma_q;
    mesgul_d  = mesgul_q;
    case (state_q)
      BOS: begin
        if (basla) begin
          state_d  = HESAP;
          mesgul_d = 1'b1;
          op_a_d   = sayi1;
          op_b_d   = sayi2;
          tur_d    = tur;
          acc_d    = {{(G+1){1'b0}}, sayi1};
          cnt_d    = '0;
          case (tur)
            OP_MUL: begin
              acc_d = {{(G+1){1'b0}}, sayi2};
              cnt_d = CNT_FULL;
            end
            OP_DIV:  cnt_d = (sayi2 == '0) ? '0 : CNT_FULL;
            OP_SQRT: begin
              op_b_d = '0;
              cnt_d  = CNT_HALF;
            end
            default: ;
          endcase
        end
      end
      HESAP: begin
        if (cnt_q == '0) begin
          state_d = BITTI;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          case (tur_q)
            OP_MUL: acc_d = mul_next;
            OP_DIV: acc_d = div_next;
            OP_SQRT: begin
              acc_d  = sq_next;
              op_b_d = sq_q_next;
            end
            default: ;
          endcase
        end
`ifdef HESAP_IPTAL_EN
        if (iptal) begin
          state_d  = BOS;
          mesgul_d = 1'b0;
        end
`endif
      end
      BITTI: begin
        state_d   = BOS;
        sonuc_d   = res_sonuc;
        gecerli_d = res_gecerli;
        tasma_d   = res_tasma;
        hazir_d   = 1'b1;
        mesgul_d  = 1'b0;
      end
      default: state_d = BOS;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; all registers, datapath included, reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= BOS;
      cnt_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      tur_q     <= '0;
      acc_q     <= '0;
      sonuc_q   <= '0;
      hazir_q   <= 1'b0;
      gecerli_q <= 1'b0;
      tasma_q   <= 1'b0;
      mesgul_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      tur_q     <= tur_d;
      acc_q     <= acc_d;
      sonuc_q   <= sonuc_d;
      hazir_q   <= hazir_d;
      gecerli_q <= gecerli_d;
      tasma_q   <= tasma_d;
      mesgul_q  <= mesgul_d;
    end
  end

  assign sonuc   = sonuc_q;
  assign hazir   = hazir_q;
  assign gecerli = gecerli_q;
  assign tasma   = tasma_q;
  assign mesgul  = mesgul_q;

endmodule

// File: tb/tb_hesap_cekirdegi.sv
// Directed bench for hesap_cekirdegi (GENISLIK=32): results, flags, latencies, back-to-back and reset abort.
module tb_hesap_cekirdegi;

  logic        clk;
  logic        rst;
  logic        basla;
  logic [31:0] sayi1;
  logic [31:0] sayi2;
  logic [2:0]  tur;
  logic [63:0] sonuc;
  logic        hazir;
  logic        gecerli;
  logic        tasma;
  logic        mesgul;
`ifdef HESAP_IPTAL_EN
  logic        iptal;
`endif

  int n_checks = 0;
  int n_errors = 0;

  hesap_cekirdegi #(.GENISLIK(32), .SAYAC_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .basla   (basla),
    .sayi1   (sayi1),
    .sayi2   (sayi2),
    .tur     (tur),
`ifdef HESAP_IPTAL_EN
    .iptal   (iptal),
`endif
    .sonuc   (sonuc),
    .hazir   (hazir),
    .gecerli (gecerli),
    .tasma   (tasma),
    .mesgul  (mesgul)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Counts edges (sampled 1ns after each) until hazir rises; returns 999 on timeout.
  task automatic wait_hazir(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!hazir && cycles < 200);
    if (!hazir) cycles = 999;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_s, input logic exp_g,
                        input logic exp_t, input int exp_lat);
    int cyc;
    @(negedge clk);
    sayi1 = a;
    sayi2 = b;
    tur   = op;
    basla = 1'b1;
    @(posedge clk);
    #1;
    basla = 1'b0;
    sayi1 = ~a;
    sayi2 = b ^ 32'h5A5A_A5A5;
    tur   = op ^ 3'b011;
    check({tag, "_mesgul"}, 64'(mesgul), 64'd1);
    wait_hazir(cyc);
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_sonuc"}, sonuc, exp_s);
    check({tag, "_gecerli"}, 64'(gecerli), 64'(exp_g));
    check({tag, "_tasma"}, 64'(tasma), 64'(exp_t));
    check({tag, "_mesgul_done"}, 64'(mesgul), 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 64'(hazir), 64'd0);
    check({tag, "_hold"}, sonuc, exp_s);
  endtask

  initial begin
    int cyc;
    rst   = 1'b0;
    basla = 1'b0;
    sayi1 = '0;
    sayi2 = '0;
    tur   = '0;
`ifdef HESAP_IPTAL_EN
    iptal = 1'b0;
`endif
    #23;
    check("rst_sonuc", sonuc, 64'd0);
    check("rst_flags", {60'd0, hazir, gecerli, tasma, mesgul}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("add_max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1_FFFF_FFFE, 1'b1, 1'b1, 2);
    run_op("sub_neg", 3'b001, 32'd5, 32'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 2);
    run_op("sub_pos", 3'b001, 32'd7, 32'd5, 64'd2, 1'b1, 1'b0, 2);
    run_op("mul_ovf", 3'b010, 32'hFFFF_FFFF, 32'd2, 64'h1_FFFF_FFFE, 1'b1, 1'b1, 34);
    run_op("mul_1k", 3'b010, 32'd1000, 32'd1000, 64'd1000000, 1'b1, 1'b0, 34);
    run_op("mul_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b1, 34);
    run_op("div_100_7", 3'b011, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1, 1'b0, 34);
    run_op("div_max", 3'b011, 32'hFFFF_FFFF, 32'h0001_0000, {32'h0000_FFFF, 32'h0000_FFFF}, 1'b1, 1'b0, 34);
    run_op("div_zero", 3'b011, 32'd9, 32'd0, 64'd0, 1'b0, 1'b1, 2);
    run_op("sqrt_1m", 3'b100, 32'd1000000, 32'd77, 64'd1000, 1'b1, 1'b0, 18);
    run_op("sqrt_max", 3'b100, 32'hFFFF_FFFF, 32'd0, 64'd65535, 1'b1, 1'b0, 18);
    run_op("sqrt_15", 3'b100, 32'd15, 32'd0, 64'd3, 1'b1, 1'b0, 18);
    run_op("sqrt_zero", 3'b100, 32'd0, 32'd0, 64'd0, 1'b1, 1'b0, 18);
    run_op("inv_op", 3'b111, 32'd12, 32'd34, 64'd0, 1'b0, 1'b0, 2);

    // basla held high across a div; the next op is taken in the hazir cycle.
    @(negedge clk);
    sayi1 = 32'd100;
    sayi2 = 32'd7;
    tur   = 3'b011;
    basla = 1'b1;
    @(posedge clk);
    #1;
    sayi1 = 32'd1000;
    sayi2 = 32'd1000;
    tur   = 3'b010;
    wait_hazir(cyc);
    check("b2b_div_lat", 64'(cyc), 64'd34);
    check("b2b_div_sonuc", sonuc, {32'd2, 32'd14});
    @(posedge clk);
    #1;
    basla = 1'b0;
    check("b2b_single_pulse", 64'(hazir), 64'd0);
    check("b2b_accept", 64'(mesgul), 64'd1);
    wait_hazir(cyc);
    check("b2b_mul_lat", 64'(cyc), 64'd34);
    check("b2b_mul_sonuc", sonuc, 64'd1000000);
    check("b2b_mul_tasma", 64'(tasma), 64'd0);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    sayi1 = 32'd123;
    sayi2 = 32'd456;
    tur   = 3'b010;
    basla = 1'b1;
    @(posedge clk);
    #1;
    basla = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_sonuc", sonuc, 64'd0);
    check("abort_flags", {60'd0, hazir, gecerli, tasma, mesgul}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_hazir", 64'(hazir), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_idle", {62'd0, hazir, mesgul}, 64'd0);
    run_op("add_after_rst", 3'b000, 32'd3, 32'd4, 64'd7, 1'b1, 1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
